arbitro_enrutador: RTL and testbench

- Routing stage between the two virtual-channel input FIFOs (VC0, VC1) and the four destination FIFOs (fifo4..fifo7).
- Each cycle it selects at most one head-of-queue word, pops it, and pushes it one cycle later into the destination FIFO addressed by the word's dest field.
- It honours per-destination almost_full backpressure.
- It owns the init/threshold FSM: it latches umbral_L/umbral_H and distributes them to all FIFOs.

---
 rtl/arbitro_enrutador.sv | 127 ++++++++++++
 tb/tb_arbitro_enrutador.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_enrutador.sv
// Routing stage from two virtual-channel FIFOs to four destination FIFOs.
// Strict VC0-over-VC1 arbitration with per-destination almost_full backpressure.
module arbitro_enrutador #(
  parameter int TAMANO_DATOS = 12,
  parameter int UMBRALES_L_H = 8,
  parameter int DEST_LSB     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_L_in,
  input  logic [UMBRALES_L_H-1:0] umbral_H_in,
  input  logic                    vc0_empty,
  input  logic                    vc1_empty,
  input  logic [TAMANO_DATOS-1:0] vc0_data,
  input  logic [TAMANO_DATOS-1:0] vc1_data,
  input  logic [3:0]              almost_full,
  output logic                    pop_vc0,
  output logic                    pop_vc1,
  output logic [3:0]              push,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [UMBRALES_L_H-1:0] umbral_L,
  output logic [UMBRALES_L_H-1:0] umbral_H,
  output logic [2:0]              estado,
  output logic                    idle
);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'b000,
    ST_RESET  = 3'b001,
    ST_INIT   = 3'b010,
    ST_IDLE   = 3'b100
  } state_t;

  state_t                  state_q;
  logic [3:0]              push_q;
  logic [TAMANO_DATOS-1:0] data_q;
  logic [UMBRALES_L_H-1:0] umbral_l_q;
  logic [UMBRALES_L_H-1:0] umbral_h_q;
  logic                    idle_q;

  logic [1:0] d0;
  logic [1:0] d1;
  logic       ok0;
  logic       ok1;
  logic       arb_en;

  assign d0  = vc0_data[DEST_LSB+1:DEST_LSB];
  assign d1  = vc1_data[DEST_LSB+1:DEST_LSB];
  assign ok0 = !vc0_empty && !almost_full[d0];
  assign ok1 = !vc1_empty && !almost_full[d1];

  // Reset and init both outrank arbitration, so they gate the pops directly.
  assign arb_en  = !reset && !init && (state_q == ST_ACTIVE);
  assign pop_vc0 = arb_en && ok0;
  assign pop_vc1 = arb_en && ok1 && !ok0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      push_q     <= 4'b0000;
      data_q     <= '0;
      umbral_l_q <= '0;
      umbral_h_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          idle_q <= 1'b0;
          if (init) state_q <= ST_INIT;
        end
        ST_INIT: begin
          umbral_l_q <= umbral_L_in;
          umbral_h_q <= umbral_H_in;
          if (init) begin
            idle_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
          end else if (!vc0_empty || !vc1_empty) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
          end else begin
            idle_q  <= 1'b1;
          end
        end
        default: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
          end else if (vc0_empty && vc1_empty) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
          end
        end
      endcase

      // data_q keeps the last forwarded word when nothing is pushed.
      if (pop_vc0) begin
        push_q <= 4'b0001 << d0;
        data_q <= vc0_data;
      end else if (pop_vc1) begin
        push_q <= 4'b0001 << d1;
        data_q <= vc1_data;
      end else begin
        push_q <= 4'b0000;
      end
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign umbral_L = umbral_l_q;
  assign umbral_H = umbral_h_q;
  assign estado   = state_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_enrutador.sv
// Bench for arbitro_enrutador: queue-modelled VC FIFOs, a pop->push scoreboard
// and one task per scenario.
module tb_arbitro_enrutador;

  localparam int W  = 12;
  localparam int EW = W + 4;
  localparam logic [2:0] S_ACTIVE = 3'b000;
  localparam logic [2:0] S_RESET  = 3'b001;
  localparam logic [2:0] S_INIT   = 3'b010;
  localparam logic [2:0] S_IDLE   = 3'b100;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [7:0]   umbral_L_in;
  logic [7:0]   umbral_H_in;
  logic         vc0_empty = 1'b1;
  logic         vc1_empty = 1'b1;
  logic [W-1:0] vc0_data = '0;
  logic [W-1:0] vc1_data = '0;
  logic [3:0]   almost_full;
  logic         pop_vc0;
  logic         pop_vc1;
  logic [3:0]   push;
  logic [W-1:0] data_out;
  logic [7:0]   umbral_L;
  logic [7:0]   umbral_H;
  logic [2:0]   estado;
  logic         idle;

  logic [W-1:0]  vc0_q[$];
  logic [W-1:0]  vc1_q[$];
  logic [EW-1:0] exp_q[$];
  logic          pop0_seen = 1'b0;
  logic          pop1_seen = 1'b0;
  int            total = 0;
  int            bad = 0;

  arbitro_enrutador dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_L_in (umbral_L_in),
    .umbral_H_in (umbral_H_in),
    .vc0_empty   (vc0_empty),
    .vc1_empty   (vc1_empty),
    .vc0_data    (vc0_data),
    .vc1_data    (vc1_data),
    .almost_full (almost_full),
    .pop_vc0     (pop_vc0),
    .pop_vc1     (pop_vc1),
    .push        (push),
    .data_out    (data_out),
    .umbral_L    (umbral_L),
    .umbral_H    (umbral_H),
    .estado      (estado),
    .idle        (idle)
  );

  // Clock / VC FIFO model
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (pop0_seen && vc0_q.size() > 0) void'(vc0_q.pop_front());
    if (pop1_seen && vc1_q.size() > 0) void'(vc1_q.pop_front());
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
    vc0_data  = (vc0_q.size() > 0) ? vc0_q[0] : '0;
    vc1_data  = (vc1_q.size() > 0) ? vc1_q[0] : '0;
  end

  // Scoreboard and pop legality monitor
  always @(negedge clk) begin : mon
    logic [EW-1:0] e;
    logic [W-1:0]  w0;
    logic [W-1:0]  w1;
    logic          ok0;
    logic          ok1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({push, data_out} !== e) begin
        bad++;
        $display("FAIL sb_push: got push=%b data=%h want push=%b data=%h",
                 push, data_out, e[EW-1:W], e[W-1:0]);
      end
    end else if (push !== 4'b0000) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected_push: got push=%b data=%h want push=0000", push, data_out);
    end
    w0  = (vc0_q.size() > 0) ? vc0_q[0] : '0;
    w1  = (vc1_q.size() > 0) ? vc1_q[0] : '0;
    ok0 = (vc0_q.size() > 0) && !almost_full[w0[9:8]];
    ok1 = (vc1_q.size() > 0) && !almost_full[w1[9:8]];
    pop0_seen = (pop_vc0 === 1'b1);
    pop1_seen = (pop_vc1 === 1'b1);
    if (pop_vc0 === 1'b1) begin
      total++;
      if (!ok0) begin
        bad++;
        $display("FAIL pop0_legal: got pop_vc0=1 want 0 (head=%h af=%b)", w0, almost_full);
      end
      exp_q.push_back({4'b0001 << w0[9:8], w0});
    end
    if (pop_vc1 === 1'b1) begin
      total++;
      if (!ok1 || ok0) begin
        bad++;
        $display("FAIL pop1_legal: got pop_vc1=1 want 0 (ok0=%b ok1=%b)", ok0, ok1);
      end
      exp_q.push_back({4'b0001 << w1[9:8], w1});
    end
  end

  // Driver tasks
  task tick;
    @(posedge clk);
    #2;
  endtask

  task wait_drain;
    int n;
    n = 0;
    while ((vc0_q.size() != 0 || vc1_q.size() != 0 || exp_q.size() != 0 || estado !== S_IDLE) && n < 300) begin
      tick;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout: got estado=%b want %b within 300 cycles", estado, S_IDLE);
    end
  endtask

  task test_reset;
    reset = 1'b1; init = 1'b0; almost_full = 4'b0000;
    umbral_L_in = 8'd0; umbral_H_in = 8'd0;
    tick; tick;
    total++;
    if (estado !== S_RESET || push !== 4'b0000 || idle !== 1'b0) begin
      bad++; $display("FAIL reset_state: got estado=%b push=%b idle=%b want 001/0000/0", estado, push, idle);
    end
    total++;
    if (umbral_L !== 8'd0 || umbral_H !== 8'd0 || data_out !== 12'h000) begin
      bad++; $display("FAIL reset_regs: got L=%0d H=%0d data=%h want 0/0/000", umbral_L, umbral_H, data_out);
    end
    reset = 1'b0; init = 1'b1; umbral_L_in = 8'd1; umbral_H_in = 8'd5;
    tick;
    total++;
    if (estado !== S_INIT || push !== 4'b0000) begin
      bad++; $display("FAIL init_enter: got estado=%b push=%b want 010/0000", estado, push);
    end
    tick;
    total++;
    if (umbral_L !== 8'd1 || umbral_H !== 8'd5) begin
      bad++; $display("FAIL init_latch: got L=%0d H=%0d want 1/5", umbral_L, umbral_H);
    end
    init = 1'b0;
    tick;
    umbral_L_in = 8'hAA; umbral_H_in = 8'h55;
    total++;
    if (estado !== S_IDLE || idle !== 1'b1 || push !== 4'b0000) begin
      bad++; $display("FAIL init_exit: got estado=%b idle=%b push=%b want 100/1/0000", estado, idle, push);
    end
    tick; tick;
    total++;
    if (umbral_L !== 8'd1 || umbral_H !== 8'd5) begin
      bad++; $display("FAIL umbral_hold: got L=%0d H=%0d want 1/5", umbral_L, umbral_H);
    end
  endtask

  task test_single_route;
    logic found;
    found = 1'b0;
    vc0_q.push_back(12'h1FB);
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (pop_vc0 === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || pop_vc1 !== 1'b0) begin
      bad++; $display("FAIL single_pop: got found=%b pop_vc1=%b want 1/0", found, pop_vc1);
    end
    tick;
    total++;
    if (push !== 4'b0010 || data_out !== 12'h1FB) begin
      bad++; $display("FAIL single_push: got push=%b data=%h want 0010/1fb", push, data_out);
    end
    tick;
    total++;
    if (estado !== S_IDLE || idle !== 1'b1 || push !== 4'b0000 || data_out !== 12'h1FB) begin
      bad++; $display("FAIL single_idle: got estado=%b idle=%b push=%b data=%h want 100/1/0000/1fb",
                      estado, idle, push, data_out);
    end
  endtask

  task test_priority;
    logic found;
    found = 1'b0;
    vc0_q.push_back(12'h2F6);
    vc1_q.push_back(12'h0AB);
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (pop_vc0 === 1'b1 || pop_vc1 === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || pop_vc0 !== 1'b1 || pop_vc1 !== 1'b0) begin
      bad++; $display("FAIL prio_first: got pop_vc0=%b pop_vc1=%b want 1/0", pop_vc0, pop_vc1);
    end
    tick;
    total++;
    if (push !== 4'b0100 || data_out !== 12'h2F6 || pop_vc1 !== 1'b1) begin
      bad++; $display("FAIL prio_vc0_push: got push=%b data=%h pop_vc1=%b want 0100/2f6/1", push, data_out, pop_vc1);
    end
    tick;
    total++;
    if (push !== 4'b0001 || data_out !== 12'h0AB) begin
      bad++; $display("FAIL prio_vc1_push: got push=%b data=%h want 0001/0ab", push, data_out);
    end
    tick;
    total++;
    if (estado !== S_IDLE) begin
      bad++; $display("FAIL prio_idle: got estado=%b want 100", estado);
    end
  endtask

  task test_no_hol;
    logic found;
    found = 1'b0;
    almost_full = 4'b1000;
    vc0_q.push_back(12'h3BB);
    vc1_q.push_back(12'h1FE);
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (pop_vc0 === 1'b1 || pop_vc1 === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin
      bad++; $display("FAIL hol_bypass: got pop_vc0=%b pop_vc1=%b want 0/1", pop_vc0, pop_vc1);
    end
    tick;
    total++;
    if (push !== 4'b0010 || data_out !== 12'h1FE || pop_vc0 !== 1'b0) begin
      bad++; $display("FAIL hol_vc1_push: got push=%b data=%h pop_vc0=%b want 0010/1fe/0", push, data_out, pop_vc0);
    end
    tick;
    total++;
    if (pop_vc0 !== 1'b0 || estado !== S_ACTIVE) begin
      bad++; $display("FAIL hol_blocked: got pop_vc0=%b estado=%b want 0/000", pop_vc0, estado);
    end
    almost_full = 4'b0000;
    #1;
    total++;
    if (pop_vc0 !== 1'b1) begin
      bad++; $display("FAIL hol_release: got pop_vc0=%b want 1", pop_vc0);
    end
    tick;
    total++;
    if (push !== 4'b1000 || data_out !== 12'h3BB) begin
      bad++; $display("FAIL hol_vc0_push: got push=%b data=%h want 1000/3bb", push, data_out);
    end
    wait_drain;
  endtask

  task test_backpressure;
    logic [W-1:0] words [3];
    int stray;
    words[0] = 12'h1A1; words[1] = 12'h1A2; words[2] = 12'h1A3;
    stray = 0;
    almost_full = 4'b0010;
    for (int i = 0; i < 3; i++) vc0_q.push_back(words[i]);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0 || push !== 4'b0000) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL bp_stall: got %0d cycles with pop/push activity want 0", stray);
    end
    almost_full = 4'b0000;
    #1;
    total++;
    if (pop_vc0 !== 1'b1) begin
      bad++; $display("FAIL bp_release: got pop_vc0=%b want 1", pop_vc0);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (push !== 4'b0010 || data_out !== words[i]) begin
        bad++; $display("FAIL bp_burst[%0d]: got push=%b data=%h want 0010/%h", i, push, data_out, words[i]);
      end
    end
    tick;
    total++;
    if (estado !== S_IDLE || push !== 4'b0000) begin
      bad++; $display("FAIL bp_idle: got estado=%b push=%b want 100/0000", estado, push);
    end
  endtask

  task test_reset_mid;
    logic found;
    found = 1'b0;
    vc0_q.push_back(12'h0C1);
    vc0_q.push_back(12'h0C2);
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (pop_vc0 === 1'b1) found = 1'b1;
    end
    tick;
    reset = 1'b1;
    #1;
    total++;
    if (!found || pop_vc0 !== 1'b0 || push !== 4'b0001 || data_out !== 12'h0C1) begin
      bad++; $display("FAIL rstmid_pending: got found=%b pop_vc0=%b push=%b data=%h want 1/0/0001/0c1",
                      found, pop_vc0, push, data_out);
    end
    tick;
    total++;
    if (push !== 4'b0000 || estado !== S_RESET || umbral_L !== 8'd0 || umbral_H !== 8'd0 || idle !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got push=%b estado=%b L=%0d H=%0d idle=%b want 0000/001/0/0/0",
                      push, estado, umbral_L, umbral_H, idle);
    end
    reset = 1'b0; init = 1'b1; umbral_L_in = 8'd2; umbral_H_in = 8'd6;
    tick; tick;
    init = 1'b0;
    tick;
    total++;
    if (estado !== S_IDLE || umbral_L !== 8'd2 || umbral_H !== 8'd6) begin
      bad++; $display("FAIL rstmid_reinit: got estado=%b L=%0d H=%0d want 100/2/6", estado, umbral_L, umbral_H);
    end
    wait_drain;
  endtask

  task test_init_mid;
    logic found;
    found = 1'b0;
    vc0_q.push_back(12'h2D1);
    vc0_q.push_back(12'h2D2);
    vc0_q.push_back(12'h2D3);
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (pop_vc0 === 1'b1) found = 1'b1;
    end
    tick;
    init = 1'b1;
    #1;
    total++;
    if (!found || pop_vc0 !== 1'b0 || push !== 4'b0100 || data_out !== 12'h2D1) begin
      bad++; $display("FAIL initmid_pending: got found=%b pop_vc0=%b push=%b data=%h want 1/0/0100/2d1",
                      found, pop_vc0, push, data_out);
    end
    tick;
    total++;
    if (estado !== S_INIT || push !== 4'b0000 || pop_vc0 !== 1'b0) begin
      bad++; $display("FAIL initmid_state: got estado=%b push=%b pop_vc0=%b want 010/0000/0", estado, push, pop_vc0);
    end
    init = 1'b0;
    wait_drain;
  endtask

  task test_back_to_back;
    logic [W-1:0] w;
    for (int c = 0; c < 80; c++) begin
      if (c < 60) begin
        w = W'($urandom_range(0, 4095));
        if ($urandom_range(0, 1) == 0) vc0_q.push_back(w);
        else vc1_q.push_back(w);
        almost_full = 4'($urandom_range(0, 15));
      end else begin
        almost_full = 4'b0000;
      end
      tick;
    end
    almost_full = 4'b0000;
    wait_drain;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; almost_full = 4'b0000;
    umbral_L_in = 8'd0; umbral_H_in = 8'd0;
    test_reset;
    test_single_route;
    test_priority;
    test_no_hol;
    test_backpressure;
    test_reset_mid;
    test_init_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
